sim_says_ctrl: RTL

Sequencing controller for the Simon Says alarm puzzle. It samples the free-running one-hot pattern generator to grow a random sequence one element per round. It plays the sequence on four LEDs, then checks the user's debounced button pulses against it. It asserts `solved` after `SEQ_LEN` correct rounds; the alarm logic uses `solved` to silence the buzzer.

---
 rtl/sim_says_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/sim_says_ctrl.sv
// Simon Says sequencing controller: grows a random sequence one element per round,
// plays it on four LEDs and checks the button entries against it.
module sim_says_ctrl #(
  parameter int unsigned SEQ_LEN    = 8,
  parameter int unsigned SHOW_TICKS = 50_000_000,
  parameter int unsigned GAP_TICKS  = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] pattern_in,
  input  logic [3:0] btn,
  output logic [3:0] led,
  output logic       busy,
  output logic       solved,
  output logic       fail,
  output logic [3:0] round
);

  localparam int unsigned MAX_TICKS = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
  localparam int unsigned TICK_W    = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
  localparam int unsigned DEPTH     = 16;

  localparam logic [TICK_W-1:0] SHOW_LAST = TICK_W'(SHOW_TICKS - 1);
  localparam logic [TICK_W-1:0] GAP_LAST  = TICK_W'(GAP_TICKS - 1);
  localparam logic [3:0]        LEN       = 4'(SEQ_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_SHOW,
    S_GAP,
    S_INPUT,
    S_FAIL,
    S_DONE
  } state_t;

  state_t            state;
  logic [1:0]        seq [DEPTH];
  logic [3:0]        idx;
  logic [TICK_W-1:0] tick;

  logic [3:0] round_last_c;
  logic [3:0] idx_next_c;
  logic [3:0] expect_c;
  logic       last_c;

  // Non-one-hot words (including all zero) fall back to index 0.
  function automatic logic [1:0] enc(input logic [3:0] p);
    logic [1:0] v;
    v = 2'd0;
    case (p)
      4'b0001: v = 2'd0;
      4'b0010: v = 2'd1;
      4'b0100: v = 2'd2;
      4'b1000: v = 2'd3;
      default: v = 2'd0;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] v);
    return 4'b0001 << v;
  endfunction

  always_comb begin
    round_last_c = round - 4'd1;
    idx_next_c   = idx + 4'd1;
    expect_c     = onehot(seq[idx]);
    last_c       = (idx == round_last_c);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      led    <= 4'b0000;
      busy   <= 1'b0;
      solved <= 1'b0;
      fail   <= 1'b0;
      round  <= 4'd0;
      idx    <= 4'd0;
      tick   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) seq[i] <= 2'd0;
    end else begin
      fail <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            seq[0] <= enc(pattern_in);
            round  <= 4'd1;
            idx    <= 4'd0;
            tick   <= '0;
            led    <= 4'b0000;
            busy   <= 1'b1;
            solved <= 1'b0;
            state  <= S_PRE;
          end
        end

        S_PRE: begin
          if (tick == GAP_LAST) begin
            tick  <= '0;
            idx   <= 4'd0;
            led   <= onehot(seq[0]);
            state <= S_SHOW;
          end else begin
            tick <= tick + 1'b1;
          end
        end

        S_SHOW: begin
          if (tick == SHOW_LAST) begin
            tick  <= '0;
            led   <= 4'b0000;
            state <= S_GAP;
          end else begin
            tick <= tick + 1'b1;
          end
        end

        S_GAP: begin
          if (tick == GAP_LAST) begin
            tick <= '0;
            if (last_c) begin
              idx   <= 4'd0;
              state <= S_INPUT;
            end else begin
              idx   <= idx_next_c;
              led   <= onehot(seq[idx_next_c]);
              state <= S_SHOW;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end

        // Only cycles carrying a button pulse are judged; multi-hot never matches.
        S_INPUT: begin
          if (btn != 4'b0000) begin
            if (btn == expect_c) begin
              if (!last_c) begin
                idx <= idx_next_c;
              end else if (round == LEN) begin
                busy   <= 1'b0;
                solved <= 1'b1;
                state  <= S_DONE;
              end else begin
                seq[round] <= enc(pattern_in);
                round      <= round + 4'd1;
                idx        <= 4'd0;
                tick       <= '0;
                state      <= S_PRE;
              end
            end else begin
              fail  <= 1'b1;
              led   <= 4'b1111;
              tick  <= '0;
              state <= S_FAIL;
            end
          end
        end

        S_FAIL: begin
          if (tick == SHOW_LAST) begin
            seq[0] <= enc(pattern_in);
            round  <= 4'd1;
            idx    <= 4'd0;
            tick   <= '0;
            led    <= 4'b0000;
            state  <= S_PRE;
          end else begin
            tick <= tick + 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
          led   <= 4'b0000;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
